mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (monitor/CPU) arbiter onto a single-port byte RAM with 1-cycle read latency.
// Define MEM_ARB_ROUNDROBIN_EN for round-robin tie-break; default is fixed monitor priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  m_req,
    input  logic                  m_we,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [7:0]            m_wdata,
    output logic                  m_ack,
    output logic                  m_rvalid,
    output logic [7:0]            m_rdata,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [7:0]            c_wdata,
    output logic                  c_ack,
    output logic                  c_rvalid,
    output logic [7:0]            c_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t                  state_q, state_d;
    logic                    grant_c_q, grant_c_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    ram_we_q, ram_we_d;
    logic [7:0]              ram_wdata_q, ram_wdata_d;
    logic                    m_ack_q, m_ack_d;
    logic                    c_ack_q, c_ack_d;
    logic                    m_rvalid_q, m_rvalid_d;
    logic                    c_rvalid_q, c_rvalid_d;
    logic [7:0]              m_rdata_q, m_rdata_d;
    logic [7:0]              c_rdata_q, c_rdata_d;
    logic                    pick_c;

    // grant_c_q doubles as the current grant and the "last granted" memory.
`ifdef MEM_ARB_ROUNDROBIN_EN
    assign pick_c = c_req && (!m_req || !grant_c_q);
`else
    assign pick_c = c_req && !m_req;
`endif

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_c_q   <= 1'b1;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            m_ack_q     <= 1'b0;
            c_ack_q     <= 1'b0;
            m_rvalid_q  <= 1'b0;
            c_rvalid_q  <= 1'b0;
            m_rdata_q   <= '0;
            c_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_c_q   <= grant_c_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            m_ack_q     <= m_ack_d;
            c_ack_q     <= c_ack_d;
            m_rvalid_q  <= m_rvalid_d;
            c_rvalid_q  <= c_rvalid_d;
            m_rdata_q   <= m_rdata_d;
            c_rdata_q   <= c_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_c_d   = grant_c_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        m_ack_d     = 1'b0;
        c_ack_d     = 1'b0;
        m_rvalid_d  = 1'b0;
        c_rvalid_d  = 1'b0;
        m_rdata_d   = m_rdata_q;
        c_rdata_d   = c_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (m_req || c_req) begin
                    grant_c_d = pick_c;
                    state_d   = ISSUE;
                    if (pick_c) begin
                        ram_addr_d  = c_addr;
                        ram_wdata_d = c_wdata;
                        ram_we_d    = c_we;
                        c_ack_d     = 1'b1;
                    end else begin
                        ram_addr_d  = m_addr;
                        ram_wdata_d = m_wdata;
                        ram_we_d    = m_we;
                        m_ack_d     = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // ram_we_q is high during this cycle exactly when the access is a write.
                state_d = ram_we_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_d = IDLE;
                if (grant_c_q) begin
                    c_rdata_d  = ram_rdata;
                    c_rvalid_d = 1'b1;
                end else begin
                    m_rdata_d  = ram_rdata;
                    m_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign m_ack     = m_ack_q;
    assign c_ack     = c_ack_q;
    assign m_rvalid  = m_rvalid_q;
    assign c_rvalid  = c_rvalid_q;
    assign m_rdata   = m_rdata_q;
    assign c_rdata   = c_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected ack/write/rvalid events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_arbiter;

    localparam int AW = 18;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          m_req = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wdata = '0;
    logic          m_ack, m_rvalid;
    logic [7:0]    m_rdata;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [7:0]    c_wdata = '0;
    logic          c_ack, c_rvalid;
    logic [7:0]    c_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = '0;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM model with one cycle read latency.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    string kname [0:4] = '{"m_ack", "c_ack", "ram_we", "m_rvalid", "c_rvalid"};

    task automatic push(input int kind, input int c, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [31:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s at cyc=%0d data=%h, required none", kname[kind], cyc, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != d) begin
                bad++;
                $display("FAIL %s: got %s cyc=%0d data=%h, required %s cyc=%0d data=%h",
                         kname[e.kind], kname[kind], cyc, d, kname[e.kind], e.cyc, e.data);
            end else begin
                $display("ok   %s cyc=%0d data=%h", kname[kind], cyc, d);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (m_ack)    check_ev(0, 32'h0);
        if (c_ack)    check_ev(1, 32'h0);
        if (ram_we)   check_ev(2, {6'b0, ram_addr, ram_wdata});
        if (m_rvalid) check_ev(3, {24'b0, m_rdata});
        if (c_rvalid) check_ev(4, {24'b0, c_rdata});
    end

    task automatic direct(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Issue one access from an IDLE arbiter and return once it is IDLE again.
    task automatic do_access(input bit is_c, input bit we, input logic [AW-1:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd);
        int n;
        n = cyc;
        if (is_c) begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd;
        end else begin
            m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
        end
        push(is_c ? 1 : 0, n + 1, 32'h0);
        if (we) push(2, n + 1, {6'b0, addr, wd});
        else    push(is_c ? 4 : 3, n + 3, {24'b0, exp_rd});
        @(posedge CLK); #1;
        m_req = 1'b0; c_req = 1'b0;
        repeat (we ? 1 : 2) begin @(posedge CLK); #1; end
    endtask

    initial begin
        int n, n0, mi, ci;
        bit win_c, rr;
`ifdef MEM_ARB_ROUNDROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        mem[18'h20000] = 8'h3C;
        mem[18'h3FFFF] = 8'hE7;

        repeat (3) @(posedge CLK);
        #1;
        direct("rst_ram_we", {31'b0, ram_we}, 32'h0);
        direct("rst_ram_addr", {14'b0, ram_addr}, 32'h0);
        direct("rst_ram_wdata", {24'b0, ram_wdata}, 32'h0);
        direct("rst_acks", {28'b0, m_ack, c_ack, m_rvalid, c_rvalid}, 32'h0);
        direct("rst_rdata", {16'b0, m_rdata, c_rdata}, 32'h0);
        reset = 1'b1;
        @(posedge CLK); #1;

        // Monitor write then read-back; CPU read of preloaded location.
        do_access(1'b0, 1'b1, 18'h00010, 8'hA5, 8'h00);
        do_access(1'b0, 1'b0, 18'h00010, 8'h00, 8'hA5);
        do_access(1'b1, 1'b0, 18'h20000, 8'h00, 8'h3C);
        direct("m_rdata_hold", {24'b0, m_rdata}, 32'hA5);
        do_access(1'b1, 1'b1, 18'h00123, 8'h5A, 8'h00);
        do_access(1'b1, 1'b0, 18'h00123, 8'h00, 8'h5A);
        do_access(1'b0, 1'b0, 18'h3FFFF, 8'h00, 8'hE7);
        direct("c_rdata_hold", {24'b0, c_rdata}, 32'h5A);

        // Monitor request pulse entirely inside a CPU read: must be ignored.
        n = cyc;
        c_req = 1'b1; c_we = 1'b0; c_addr = 18'h00010;
        push(1, n + 1, 32'h0);
        push(4, n + 3, 32'hA5);
        @(posedge CLK); #1;
        c_req = 1'b0;
        m_req = 1'b1; m_we = 1'b1; m_addr = 18'h00010; m_wdata = 8'h77;
        @(posedge CLK); #1;
        m_req = 1'b0;
        @(posedge CLK); #1;
        repeat (2) begin @(posedge CLK); #1; end

        // Reset asserted during the ISSUE cycle of a read aborts it.
        n = cyc;
        m_req = 1'b1; m_we = 1'b0; m_addr = 18'h3FFFF;
        push(0, n + 1, 32'h0);
        @(posedge CLK); #1;
        m_req = 1'b0;
        reset = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        direct("abort_ram_we", {31'b0, ram_we}, 32'h0);
        direct("abort_ram_addr", {14'b0, ram_addr}, 32'h0);
        direct("abort_m_rdata", {24'b0, m_rdata}, 32'h0);
        repeat (3) begin @(posedge CLK); #1; end

        do_access(1'b0, 1'b1, 18'h00000, 8'hFF, 8'h00);
        do_access(1'b0, 1'b0, 18'h00000, 8'h00, 8'hFF);

        // Both ports hold req high for four writes each.
        n0 = cyc; mi = 0; ci = 0;
        m_req = 1'b1; m_we = 1'b1; m_addr = 18'h00100; m_wdata = 8'h10;
        c_req = 1'b1; c_we = 1'b1; c_addr = 18'h00200; c_wdata = 8'h20;
        for (int k = 0; k < 8; k++) begin
            win_c = rr ? k[0] : (k >= 4);
            if (win_c) begin
                push(1, n0 + 1 + 2 * k, 32'h0);
                push(2, n0 + 1 + 2 * k, {6'b0, 18'h00200 + 18'(ci), 8'h20 + 8'(ci)});
            end else begin
                push(0, n0 + 1 + 2 * k, 32'h0);
                push(2, n0 + 1 + 2 * k, {6'b0, 18'h00100 + 18'(mi), 8'h10 + 8'(mi)});
            end
            @(posedge CLK); #1;
            if (win_c) begin
                ci++;
                if (ci == 4) c_req = 1'b0;
                c_addr = 18'h00200 + 18'(ci); c_wdata = 8'h20 + 8'(ci);
            end else begin
                mi++;
                if (mi == 4) m_req = 1'b0;
                m_addr = 18'h00100 + 18'(mi); m_wdata = 8'h10 + 8'(mi);
            end
            @(posedge CLK); #1;
        end

        do_access(1'b1, 1'b0, 18'h00103, 8'h00, 8'h13);
        do_access(1'b0, 1'b0, 18'h00202, 8'h00, 8'h22);

        repeat (4) begin @(posedge CLK); #1; end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
